// File: rtl/regfile_pkg.sv
// regfile_pkg: shared geometry defaults and FSM state type for
// regfile_wr_sched. No ports; imported by the top and its scanner.
package regfile_pkg;

  localparam int DEF_SRAM_DEPTH = 32;
  localparam int DEF_SRAM_INDEX = 5;
  localparam int DEF_SRAM_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 8;
  localparam int DEF_NUM_WPORT  = 6;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_scan.sv
// rr_grant_scan: combinational round-robin scan of write requesters.
// Starts at rr_ptr_i, grants up to NUM_WPORT valid requesters and maps
// the k-th grant to write port k.
// Ports: en_i (scan enable), valid_i, addr_i (packed), rr_ptr_i;
//        grant_o, port_vld_o, port_sel_o (packed requester index per
//        port), any_o (some grant), next_ptr_o (pointer after grants).
// Macro WR_COLLISION_CHECK_EN: skip a requester whose address matches
// one already granted this cycle; it uses no port and retries later.
module rr_grant_scan
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_WPORT  = DEF_NUM_WPORT,
  parameter int SRAM_INDEX = DEF_SRAM_INDEX,
  parameter int RIW        = idx_w(NUM_REQ)
) (
  input  logic                          en_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0] addr_i,
  input  logic [RIW-1:0]                rr_ptr_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_WPORT-1:0]          port_vld_o,
  output logic [NUM_WPORT*RIW-1:0]      port_sel_o,
  output logic                          any_o,
  output logic [RIW-1:0]                next_ptr_o
);

`ifdef WR_COLLISION_CHECK_EN
  logic [SRAM_INDEX-1:0] gaddr [NUM_WPORT];
  logic [SRAM_INDEX-1:0] cur_addr;
`else
  logic unused_addr;
  assign unused_addr = ^addr_i;
`endif

  int             pos;
  int             cnt;
  logic [RIW-1:0] idx;
  logic           hit;

  always_comb begin
    grant_o    = '0;
    port_vld_o = '0;
    port_sel_o = '0;
    any_o      = 1'b0;
    next_ptr_o = rr_ptr_i;
    pos        = 0;
    cnt        = 0;
    idx        = '0;
    hit        = 1'b0;
`ifdef WR_COLLISION_CHECK_EN
    cur_addr = '0;
    for (int p = 0; p < NUM_WPORT; p++) begin
      gaddr[p] = '0;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      // position in scan order, wrapped without a divider
      pos = int'(rr_ptr_i) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = RIW'(pos);
      hit = 1'b0;
`ifdef WR_COLLISION_CHECK_EN
      cur_addr = addr_i[idx*SRAM_INDEX +: SRAM_INDEX];
      for (int j = 0; j < NUM_WPORT; j++) begin
        if (j < cnt && gaddr[j] == cur_addr) begin
          hit = 1'b1;
        end
      end
`endif
      if (en_i && valid_i[idx] && cnt < NUM_WPORT && !hit) begin
        grant_o[idx] = 1'b1;
        for (int p = 0; p < NUM_WPORT; p++) begin
          if (p == cnt) begin
            port_vld_o[p]            = 1'b1;
            port_sel_o[p*RIW +: RIW] = idx;
`ifdef WR_COLLISION_CHECK_EN
            gaddr[p] = cur_addr;
`endif
          end
        end
        cnt        = cnt + 1;
        any_o      = 1'b1;
        next_ptr_o = (pos == NUM_REQ - 1) ? '0 : RIW'(pos + 1);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: clears the register file after reset (INIT), then
// arbitrates writeback requesters onto NUM_WPORT write ports (RUN).
// Ports: clk, reset (async, active high); req_valid_i/req_addr_i/
//        req_data_i with req_ready_o grant; registered we_o, wr_addr_o,
//        wr_data_o; init_done_o high in RUN.
// Macro WR_COLLISION_CHECK_EN: same-cycle address collisions are
// deferred instead of both being written.
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int SRAM_INDEX = DEF_SRAM_INDEX,
  parameter int SRAM_WIDTH = DEF_SRAM_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_WPORT  = DEF_NUM_WPORT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0]   req_addr_i,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_WPORT-1:0]            we_o,
  output logic [NUM_WPORT*SRAM_INDEX-1:0] wr_addr_o,
  output logic [NUM_WPORT*SRAM_WIDTH-1:0] wr_data_o,
  output logic                            init_done_o
);

  localparam int RIW = idx_w(NUM_REQ);
  localparam int BW  = idx_w(SRAM_DEPTH + NUM_WPORT) + 1;

  state_e                          state_q, state_d;
  logic [BW-1:0]                   base_q, base_d;
  logic [RIW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_WPORT-1:0]            we_q, we_d;
  logic [NUM_WPORT*SRAM_INDEX-1:0] addr_q, addr_d;
  logic [NUM_WPORT*SRAM_WIDTH-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]              grant;
  logic [NUM_WPORT-1:0]            port_vld;
  logic [NUM_WPORT*RIW-1:0]        port_sel;
  logic                            any_grant;
  logic [RIW-1:0]                  next_ptr;
  logic [RIW-1:0]                  sel;

  rr_grant_scan #(
    .NUM_REQ    (NUM_REQ),
    .NUM_WPORT  (NUM_WPORT),
    .SRAM_INDEX (SRAM_INDEX),
    .RIW        (RIW)
  ) u_scan (
    .en_i       (state_q == ST_RUN),
    .valid_i    (req_valid_i),
    .addr_i     (req_addr_i),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant),
    .port_vld_o (port_vld),
    .port_sel_o (port_sel),
    .any_o      (any_grant),
    .next_ptr_o (next_ptr)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = '0;
    addr_d   = '0;
    data_d   = '0;
    sel      = '0;
    unique case (state_q)
      ST_INIT: begin
        // base_q walks in strides of NUM_WPORT; once it passes the
        // last entry the final clear is already on the outputs
        if (int'(base_q) >= SRAM_DEPTH) begin
          state_d = ST_RUN;
        end else begin
          base_d = base_q + BW'(NUM_WPORT);
          for (int p = 0; p < NUM_WPORT; p++) begin
            if (int'(base_q) + p < SRAM_DEPTH) begin
              we_d[p] = 1'b1;
              addr_d[p*SRAM_INDEX +: SRAM_INDEX] =
                SRAM_INDEX'(int'(base_q) + p);
            end
          end
        end
      end
      ST_RUN: begin
        if (any_grant) begin
          rr_ptr_d = next_ptr;
        end
        for (int p = 0; p < NUM_WPORT; p++) begin
          sel = port_sel[p*RIW +: RIW];
          if (port_vld[p]) begin
            we_d[p] = 1'b1;
            addr_d[p*SRAM_INDEX +: SRAM_INDEX] =
              req_addr_i[sel*SRAM_INDEX +: SRAM_INDEX];
            data_d[p*SRAM_WIDTH +: SRAM_WIDTH] =
              req_data_i[sel*SRAM_WIDTH +: SRAM_WIDTH];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_INIT;
      base_q   <= '0;
      rr_ptr_q <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign req_ready_o = grant;
  assign we_o        = we_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign init_done_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: scoreboard bench for regfile_wr_sched.
// Driver predicts grants and port writes; monitor checks outputs.
module tb_regfile_wr_sched;

  localparam int NR    = 8;
  localparam int NW    = 6;
  localparam int AI    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int CW    = 192;

  logic               clk = 1'b0;
  logic               reset;
  logic [NR-1:0]      req_valid_i;
  logic [NR*AI-1:0]   req_addr_i;
  logic [NR*DW-1:0]   req_data_i;
  logic [NR-1:0]      req_ready_o;
  logic [NW-1:0]      we_o;
  logic [NW*AI-1:0]   wr_addr_o;
  logic [NW*DW-1:0]   wr_data_o;
  logic               init_done_o;

  typedef struct {
    int             cyc;
    logic [NW-1:0]    we;
    logic [NW*AI-1:0] addr;
    logic [NW*DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic [NR-1:0] pend;
  logic [AI-1:0] paddr [NR];
  logic [DW-1:0] pdata [NR];
  logic [AI-1:0] nxt_addr [NR];
  logic [DW-1:0] nxt_data [NR];
  int            rr_m;
  logic [NR-1:0] last_rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_wr_sched #(
    .SRAM_DEPTH (DEPTH),
    .SRAM_INDEX (AI),
    .SRAM_WIDTH (DW),
    .NUM_REQ    (NR),
    .NUM_WPORT  (NW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .we_o        (we_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .init_done_o (init_done_o)
  );

  task automatic chk(input string nm, input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // monitor: one expected write set per granted cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("wr_we", CW'(we_o), CW'(e.we));
        chk("wr_addr", CW'(wr_addr_o), CW'(e.addr));
        chk("wr_data", CW'(wr_data_o), CW'(e.data));
      end else begin
        chk("idle_we", CW'(we_o), CW'(0));
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    pend = '0;
    rr_m = 0;
    for (int r = 0; r < NR; r++) begin
      paddr[r] = '0;
      pdata[r] = '0;
    end
  endtask

  task automatic rand_next();
    for (int r = 0; r < NR; r++) begin
      if ($urandom_range(0, 3) == 0)
        nxt_addr[r] = AI'($urandom_range(0, 3));
      else
        nxt_addr[r] = AI'($urandom);
      nxt_data[r] = $urandom;
    end
  endtask

  // one cycle: new requests join pending ones, predict and check grants
  task automatic step(input logic [NR-1:0] mask);
    logic [NR-1:0] rdy;
    exp_t          e;
    int            cnt;
    int            last;
    int            r;
    bit            col;
`ifdef WR_COLLISION_CHECK_EN
    logic [AI-1:0] gq[$];
`endif
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && mask[i]) begin
        pend[i]  = 1'b1;
        paddr[i] = nxt_addr[i];
        pdata[i] = nxt_data[i];
      end
      req_addr_i[i*AI +: AI] = paddr[i];
      req_data_i[i*DW +: DW] = pdata[i];
    end
    req_valid_i = pend;
    #1;
    rdy    = '0;
    cnt    = 0;
    last   = -1;
    e.cyc  = cyc + 1;
    e.we   = '0;
    e.addr = '0;
    e.data = '0;
    for (int i = 0; i < NR; i++) begin
      r   = (rr_m + i) % NR;
      col = 1'b0;
`ifdef WR_COLLISION_CHECK_EN
      foreach (gq[j]) if (gq[j] == paddr[r]) col = 1'b1;
`endif
      if (pend[r] && cnt < NW && !col) begin
        rdy[r]               = 1'b1;
        e.we[cnt]            = 1'b1;
        e.addr[cnt*AI +: AI] = paddr[r];
        e.data[cnt*DW +: DW] = pdata[r];
`ifdef WR_COLLISION_CHECK_EN
        gq.push_back(paddr[r]);
`endif
        cnt++;
        last = r;
      end
    end
    last_rdy = req_ready_o;
    chk("ready", CW'(req_ready_o), CW'(rdy));
    if (last >= 0) begin
      sb.push_back(e);
      rr_m = (last + 1) % NR;
      pend = pend & ~rdy;
    end
  endtask

  task automatic reset_and_init();
    logic [NW-1:0]    ew;
    logic [NW*AI-1:0] ea;
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", CW'(we_o), CW'(0));
    chk("rst_addr", CW'(wr_addr_o), CW'(0));
    chk("rst_data", CW'(wr_data_o), CW'(0));
    chk("rst_done", CW'(init_done_o), CW'(0));
    chk("rst_ready", CW'(req_ready_o), CW'(0));
    @(negedge clk);
    reset       = 1'b0;
    req_valid_i = '0;
    model_reset();
    #1;
    chk("rel_we", CW'(we_o), CW'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      ew = '0;
      ea = '0;
      for (int p = 0; p < NW; p++) begin
        if (k * NW + p < DEPTH) begin
          ew[p]          = 1'b1;
          ea[p*AI +: AI] = AI'(k * NW + p);
        end
      end
      chk("init_we", CW'(we_o), CW'(ew));
      chk("init_addr", CW'(wr_addr_o), CW'(ea));
      chk("init_data", CW'(wr_data_o), CW'(0));
      chk("init_done_lo", CW'(init_done_o), CW'(0));
    end
    @(posedge clk);
    #1;
    chk("init_done_hi", CW'(init_done_o), CW'(1));
    chk("run_we_idle", CW'(we_o), CW'(0));
    mon_en = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] m;
    reset       = 1'b1;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    last_rdy    = '0;
    model_reset();
    rand_next();
    reset_and_init();

    // reset pulse in the third RUN cycle
    rand_next();
    step('1);
    chk("run1_rdy", CW'(last_rdy), CW'(8'h3F));
    rand_next();
    step('1);
    chk("run2_rdy", CW'(last_rdy), CW'(8'hCF));
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("pulse_we", CW'(we_o), CW'(0));
    chk("pulse_done", CW'(init_done_o), CW'(0));
    chk("pulse_ready", CW'(req_ready_o), CW'(0));
    reset_and_init();

    // two sparse requesters land on ports 0 and 1
    rand_next();
    nxt_addr[2] = 5'd7;
    nxt_addr[5] = 5'd9;
    step(8'h24);
    chk("two_rdy", CW'(last_rdy), CW'(8'h24));
    step(8'h80);
    chk("ptr_wrap_rdy", CW'(last_rdy), CW'(8'h80));

    // all valid from pointer 0, then wraparound grant
    rand_next();
    step('1);
    chk("all_rdy0", CW'(last_rdy), CW'(8'h3F));
    rand_next();
    step('1);
    chk("all_rdy1", CW'(last_rdy), CW'(8'hCF));
    step('0);
    chk("all_rdy2", CW'(last_rdy), CW'(8'h30));

    // same address from requesters 1 and 3
    rand_next();
    nxt_addr[1] = 5'd4;
    nxt_addr[3] = 5'd4;
    step(8'h0A);
`ifdef WR_COLLISION_CHECK_EN
    chk("coll_rdy0", CW'(last_rdy), CW'(8'h02));
    step('0);
    chk("coll_rdy1", CW'(last_rdy), CW'(8'h08));
`else
    chk("coll_rdy", CW'(last_rdy), CW'(8'h0A));
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      rand_next();
      if ($urandom_range(0, 4) == 0) m = '1;
      else m = NR'($urandom & $urandom);
      step(m);
    end
    for (int n = 0; n < 20 && pend != '0; n++) begin
      step('0);
    end
    chk("drain_pend", CW'(pend), CW'(0));
    @(negedge clk);
    req_valid_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", CW'(sb.size()), CW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wr_sched.md
REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 32: register file entries.
REQ-002 SHALL have parameter SRAM_INDEX, default 5: address width.
REQ-003 SHALL have parameter SRAM_WIDTH, default 32: data width.
REQ-004 SHALL have parameter NUM_REQ, default 8: writeback requesters.
REQ-005 SHALL have parameter NUM_WPORT, default 6: register file write ports.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid_i  in  NUM_REQ  per-requester write request.
REQ-009 SHALL have port req_addr_i  in  NUM_REQ*SRAM_INDEX  packed target addresses; requester r at slice r.
REQ-010 SHALL have port req_data_i  in  NUM_REQ*SRAM_WIDTH  packed write data.
REQ-011 SHALL have port req_ready_o  out  NUM_REQ  combinational grant; transfer occurs when valid and ready are both high.
REQ-012 SHALL have port we_o  out  NUM_WPORT  registered write enables to register file write ports.
REQ-013 SHALL have port wr_addr_o  out  NUM_WPORT*SRAM_INDEX  registered packed write addresses.
REQ-014 SHALL have port wr_data_o  out  NUM_WPORT*SRAM_WIDTH  registered packed write data.
REQ-015 SHALL have port init_done_o  out  1  high once clearing is complete.

Function
REQ-016 SHALL implement two states: INIT (clear register file) and RUN (arbitrate requests).
REQ-017 In INIT cycle k, SHALL drive port p with address k*NUM_WPORT+p, data 0, and we set only where that address is below SRAM_DEPTH.
REQ-018 SHALL leave INIT after the cycle covering address SRAM_DEPTH-1, entering RUN with init_done_o=1 on the next cycle.
REQ-019 With the defaults, SHALL take 6 INIT cycles; the last cycle writes addresses 30 and 31 on ports 0 and 1 only.
REQ-020 SHALL hold req_ready_o at all zeros in INIT.
REQ-021 In RUN, SHALL scan requesters from round-robin pointer rr_ptr upward, modulo NUM_REQ.
REQ-022 In RUN, SHALL grant at most NUM_WPORT valid requesters per cycle.
REQ-023 In RUN, the k-th granted requester in scan order SHALL be mapped to write port k.
REQ-024 SHALL drive req_ready_o high only for requesters that are granted.
REQ-025 SHALL place a granted write on we_o/wr_addr_o/wr_data_o exactly one cycle after the handshake (latency 1).
REQ-026 SHALL drive we_o to 0 on any unused port, with address and data held at 0.
REQ-027 When any grant occurs, SHALL set rr_ptr to (last granted index + 1) mod NUM_REQ; otherwise rr_ptr SHALL be unchanged.
REQ-028 A requester with valid high and ready low SHALL hold its address and data stable; the block SHALL not drop it.
REQ-029 Ready SHALL never depend on the ready of another requester outside the scan order.
REQ-030 With fewer than NUM_WPORT valid requesters, SHALL grant all of them in the same cycle.

Reset
REQ-031 While reset is high, SHALL hold we_o=0, wr_addr_o=0, wr_data_o=0, init_done_o=0, req_ready_o=0, and rr_ptr=0.
REQ-032 Reset asserted at any point, including mid-INIT or mid-RUN, SHALL discard pending output writes and restart INIT from address 0 after deassertion.

Configuration
REQ-033 With WR_COLLISION_CHECK_EN defined, a requester whose address equals that of an earlier granted requester in the same cycle SHALL not be granted and SHALL not consume a port.
REQ-034 With WR_COLLISION_CHECK_EN defined, scanning SHALL continue past a collided requester, and the collided requester SHALL retry in a later cycle.
REQ-035 Without WR_COLLISION_CHECK_EN, same-address requesters SHALL all be granted; the write on the higher-numbered port takes effect.

Structure
REQ-036 Package regfile_pkg SHALL hold the default depth, index, width and port-count constants and the INIT/RUN state enum.
REQ-037 Combinational round-robin selection SHALL reside in one sub-module, rr_grant_scan, which outputs grant vector and port mapping.

Verification
REQ-038 Reset release -> we_o=6'b111111 for cycles 1-5 with addresses 0..29, then 6'b000011 with addresses 30 and 31, then init_done_o=1.
REQ-039 All 8 requesters valid, rr_ptr=0 -> ready=8'h3F, we_o all ones on the next cycle, and rr_ptr=6; the next cycle grants requesters 6, 7, 0, 1, 2, 3.
REQ-040 Requesters 2 and 5 valid with addresses 7 and 9 -> both granted on ports 0 and 1; next cycle we_o=6'b000011.
REQ-041 Requesters 1 and 3 both target address 4 -> with the macro, only requester 1 is ready and requester 3 is granted the following cycle; without it, both are ready and port 1 carries requester 3.
REQ-042 Reset pulsed during the third RUN cycle -> we_o=0 immediately, init_done_o=0, and the clearing sequence restarts at address 0.
